// File: rtl/ysyx_22040125_pkg.sv
// Shared definitions for the ysyx_22040125 load/store unit: access size
// encodings, FSM state type and the default memory bus width.
package ysyx_22040125_pkg;

  localparam int DATA_W = 64;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Byte-strobe pattern for an access of the given size, anchored at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ysyx_22040125_load_ext.sv
// Load lane extraction: shifts the addressed bytes of the aligned read word
// down to bit 0, truncates to the access size and sign/zero extends to 64 bits.
module ysyx_22040125_load_ext
  import ysyx_22040125_pkg::*;
#(
  parameter int DATA_W = ysyx_22040125_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [63:0]       result
);

  logic [DATA_W-1:0] lane;

  assign lane = rdata >> {offset, 3'b000};

  // Truncate to the access size and replicate the top bit unless unsigned.
  always_comb begin
    result = '0;
    case (size)
      SZ_B:    result = {{56{~is_unsigned & lane[7]}},  lane[7:0]};
      SZ_H:    result = {{48{~is_unsigned & lane[15]}}, lane[15:0]};
      SZ_W:    result = {{32{~is_unsigned & lane[31]}}, lane[31:0]};
      default: result = lane[63:0];
    endcase
  end

endmodule

// File: rtl/ysyx_22040125_lsu.sv
// Single-outstanding load/store unit. Captures one request, issues an aligned
// memory access (or short-circuits misaligned ones), then presents the
// extended load result until writeback accepts it.
module ysyx_22040125_lsu
  import ysyx_22040125_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = ysyx_22040125_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  // request side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_rd,
  // memory side
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  // result side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_rdata,
  output logic [4:0]        out_rd,
  output logic              out_misalign
);

  lsu_state_t        state_reg, state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic              wen_reg;
  logic              unsigned_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [4:0]        rd_reg;
  logic [63:0]       rdata_reg;
  logic              misalign_reg;

  logic              accept;
  logic              in_misalign;
  logic [2:0]        offset;
  logic [63:0]       load_value;

  // in_ready depends only on state and reset, never on in_valid.
  assign in_ready = rst_n & (state_reg == IDLE);
  assign accept   = in_valid & in_ready;
  assign offset   = addr_reg[2:0];

  // Natural alignment check on the incoming address.
  always_comb begin
    in_misalign = 1'b0;
    case (in_size)
      SZ_H:    in_misalign = in_addr[0];
      SZ_W:    in_misalign = |in_addr[1:0];
      SZ_D:    in_misalign = |in_addr[2:0];
      default: in_misalign = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; misaligned requests bypass memory entirely.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept)        state_next = in_misalign ? DONE : REQ;
      REQ:  if (mem_req_ready) state_next = WAIT;
      WAIT: if (mem_rsp_valid) state_next = DONE;
      DONE: if (out_ready)     state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  ysyx_22040125_load_ext #(
    .DATA_W(DATA_W)
  ) u_load_ext (
    .rdata      (mem_rsp_rdata),
    .offset     (offset),
    .size       (size_reg),
    .is_unsigned(unsigned_reg),
    .result     (load_value)
  );

  // Request capture and result registration; results stay put until next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      size_reg     <= '0;
      wen_reg      <= 1'b0;
      unsigned_reg <= 1'b0;
      wdata_reg    <= '0;
      rd_reg       <= '0;
      rdata_reg    <= '0;
      misalign_reg <= 1'b0;
    end else if (accept) begin
      addr_reg     <= in_addr;
      size_reg     <= in_size;
      wen_reg      <= in_wen;
      unsigned_reg <= in_unsigned;
      wdata_reg    <= in_wdata;
      rd_reg       <= in_rd;
      rdata_reg    <= '0;
      misalign_reg <= in_misalign;
    end else if (state_reg == WAIT && mem_rsp_valid) begin
      rdata_reg    <= wen_reg ? 64'd0 : load_value;
    end
  end

  // Memory request is driven purely from captured registers, so it is stable
  // for as long as the request waits for mem_req_ready.
  assign mem_req_valid = (state_reg == REQ);
  assign mem_req_addr  = {addr_reg[ADDR_W-1:3], 3'b000};
  assign mem_req_wen   = wen_reg;
  assign mem_req_wdata = wdata_reg << {offset, 3'b000};
  assign mem_req_wmask = wen_reg ? (size_mask(size_reg) << offset) : 8'h00;

  assign out_valid    = (state_reg == DONE);
  assign out_rdata    = rdata_reg;
  assign out_rd       = rd_reg;
  assign out_misalign = misalign_reg;

endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Scoreboard bench for ysyx_22040125_lsu: expected results are queued at
// issue and popped when the LSU presents its result.
module tb_ysyx_22040125_lsu;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_wen, in_unsigned;
  logic [1:0]        in_size;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [4:0]        in_rd;
  logic              mem_req_valid, mem_req_ready, mem_req_wen;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;
  logic              out_valid, out_ready, out_misalign;
  logic [63:0]       out_rdata;
  logic [4:0]        out_rd;

  typedef struct {
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ysyx_22040125_lsu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_rd(out_rd), .out_misalign(out_misalign)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: bitwise lane extraction with explicit extension.
  function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [2:0] off,
                                         input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    logic [63:0] res;
    int nbits;
    sh    = rdata >> (int'(off) * 8);
    nbits = 8 << size;
    res   = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < nbits) res[i] = sh[i];
      else           res[i] = uns ? 1'b0 : sh[nbits-1];
    end
    return res;
  endfunction

  function automatic logic [7:0] m_mask(input logic [2:0] off, input logic [1:0] size);
    logic [7:0] m;
    int nb;
    nb = 1 << size;
    for (int i = 0; i < 8; i++) m[i] = (i >= int'(off)) && (i < int'(off) + nb);
    return m;
  endfunction

  task automatic check_req(input logic wen, input logic [31:0] e_addr, input logic [7:0] e_mask,
                           input logic [63:0] e_wdata);
    check_eq("req_valid", mem_req_valid, 1'b1);
    check_eq("req_addr",  mem_req_addr, e_addr);
    check_eq("req_wen",   mem_req_wen, wen);
    check_eq("req_wmask", mem_req_wmask, e_mask);
    check_eq("req_wdata", mem_req_wdata, e_wdata);
    check_eq("in_ready_busy", in_ready, 1'b0);
    check_eq("out_valid_busy", out_valid, 1'b0);
  endtask

  task automatic do_txn(input logic wen, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                        input logic [63:0] mem_rdata, input logic mis,
                        input logic [31:0] e_addr, input logic [7:0] e_mask,
                        input logic [63:0] e_wdata, input logic [63:0] e_rdata,
                        input int req_stall, input int out_stall);
    exp_t e;
    e.rdata = e_rdata;
    e.rd    = rd;
    e.mis   = mis;
    sb_q.push_back(e);
    $display("txn wen=%0d size=%0d uns=%0d addr=0x%08h rd=%0d mis=%0d", wen, size, uns, addr, rd, mis);
    @(negedge clk);
    in_valid = 1'b1; in_wen = wen; in_size = size; in_unsigned = uns;
    in_addr = addr; in_wdata = wdata; in_rd = rd;
    check_eq("in_ready_idle", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    // Scramble the request bus to prove the LSU works from captured copies.
    in_valid = 1'b0; in_addr = $urandom; in_wdata = {$urandom, $urandom};
    in_rd = ~rd; in_size = ~size; in_wen = ~wen; in_unsigned = ~uns;
    if (mis) begin
      check_eq("mis_no_req", mem_req_valid, 1'b0);
      check_eq("mis_latency", out_valid, 1'b1);
    end else begin
      mem_req_ready = 1'b0;
      for (int i = 0; i < req_stall; i++) begin
        check_req(wen, e_addr, e_mask, e_wdata);
        @(negedge clk);
      end
      check_req(wen, e_addr, e_mask, e_wdata);
      mem_req_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_req_ready = 1'b0;
      check_eq("wait_no_req", mem_req_valid, 1'b0);
      check_eq("wait_no_out", out_valid, 1'b0);
      mem_rsp_valid = 1'b1; mem_rsp_rdata = mem_rdata;
      @(posedge clk);
      @(negedge clk);
      check_eq("done_latency", out_valid, 1'b1);
    end
    // Stray request and stray response during DONE must both be ignored.
    mem_rsp_valid = 1'b1; mem_rsp_rdata = {$urandom, $urandom};
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < out_stall; i++) begin
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_in_ready", in_ready, 1'b0);
      check_eq("hold_no_req", mem_req_valid, 1'b0);
      check_eq("hold_rdata", out_rdata, sb_q[0].rdata);
      check_eq("hold_rd", out_rd, sb_q[0].rd);
      check_eq("hold_mis", out_misalign, sb_q[0].mis);
      @(negedge clk);
    end
    check_eq("out_valid", out_valid, 1'b1);
    e = sb_q.pop_front();
    check_eq("out_rdata", out_rdata, e.rdata);
    check_eq("out_rd", out_rd, e.rd);
    check_eq("out_misalign", out_misalign, e.mis);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; mem_rsp_valid = 1'b0;
    check_eq("back_idle_valid", out_valid, 1'b0);
    check_eq("back_idle_ready", in_ready, 1'b1);
  endtask

  logic        r_wen, r_uns, r_mis;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [63:0] r_wdata, r_rdata, r_exp;
  logic [7:0]  r_mask;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_wen = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
    in_addr = '0; in_wdata = '0; in_rd = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_req_valid", mem_req_valid, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_rdata", out_rdata, 64'd0);
    check_eq("rst_out_rd", out_rd, 5'd0);
    check_eq("rst_out_mis", out_misalign, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1'b1);

    // Signed byte load from lane 3.
    do_txn(1'b0, 2'd0, 1'b0, 32'h8000_0003, 64'd0, 5'd7, 64'h00000000_80000000, 1'b0,
           32'h8000_0000, 8'h00, 64'd0, 64'hFFFFFFFF_FFFFFF80, 0, 0);
    // Half store to lanes 6-7.
    do_txn(1'b1, 2'd1, 1'b0, 32'h8000_0006, 64'h0000_0000_0000_BEEF, 5'd3, 64'h12345678_9ABCDEF0, 1'b0,
           32'h8000_0000, 8'hC0, 64'hBEEF0000_00000000, 64'd0, 0, 0);
    // Misaligned word load.
    do_txn(1'b0, 2'd2, 1'b0, 32'h8000_0002, 64'd0, 5'd11, 64'hFFFFFFFF_FFFFFFFF, 1'b1,
           32'h8000_0000, 8'h00, 64'd0, 64'd0, 0, 0);
    // Double load with memory back-pressure.
    do_txn(1'b0, 2'd3, 1'b0, 32'h8000_0008, 64'd0, 5'd21, 64'h88776655_44332211, 1'b0,
           32'h8000_0008, 8'h00, 64'd0, 64'h88776655_44332211, 5, 0);
    // Unsigned half load with writeback back-pressure.
    do_txn(1'b0, 2'd1, 1'b1, 32'h8000_000E, 64'd0, 5'd30, 64'hABCD0000_00000000, 1'b0,
           32'h8000_0008, 8'h00, 64'd0, 64'h00000000_0000ABCD, 0, 3);
    // Signed half and signed word loads.
    do_txn(1'b0, 2'd1, 1'b0, 32'h8000_0004, 64'd0, 5'd1, 64'h00008001_00000000, 1'b0,
           32'h8000_0000, 8'h00, 64'd0, 64'hFFFFFFFF_FFFF8001, 0, 0);
    do_txn(1'b0, 2'd2, 1'b0, 32'h8000_0014, 64'd0, 5'd2, 64'h90000000_00000000, 1'b0,
           32'h8000_0010, 8'h00, 64'd0, 64'hFFFFFFFF_90000000, 0, 0);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 24; n++) begin
      r_wen   = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_uns   = 1'($urandom_range(0, 1));
      r_addr  = 32'h8000_0000 | ($urandom & 32'h0000_00FF);
      r_wdata = {$urandom, $urandom};
      r_rdata = {$urandom, $urandom};
      r_mis   = (int'(r_addr[2:0]) % (1 << r_size)) != 0;
      r_mask  = r_wen ? m_mask(r_addr[2:0], r_size) : 8'h00;
      r_exp   = (r_wen || r_mis) ? 64'd0 : m_load(r_rdata, r_addr[2:0], r_size, r_uns);
      do_txn(r_wen, r_size, r_uns, r_addr, r_wdata, 5'($urandom_range(0, 31)), r_rdata, r_mis,
             r_addr & 32'hFFFF_FFF8, r_mask, r_wdata << (int'(r_addr[2:0]) * 8), r_exp,
             $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset while waiting for a response, then a stray response.
    $display("txn reset-in-WAIT");
    @(negedge clk);
    in_valid = 1'b1; in_wen = 1'b0; in_size = 2'd3; in_unsigned = 1'b0;
    in_addr = 32'h8000_0010; in_rd = 5'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    check_eq("rw_wait_req", mem_req_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("rw_in_ready", in_ready, 1'b0);
    check_eq("rw_req_valid", mem_req_valid, 1'b0);
    check_eq("rw_req_addr", mem_req_addr, 32'd0);
    check_eq("rw_out_valid", out_valid, 1'b0);
    check_eq("rw_out_rdata", out_rdata, 64'd0);
    check_eq("rw_out_rd", out_rd, 5'd0);
    check_eq("rw_out_mis", out_misalign, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("rw_stray_out_valid", out_valid, 1'b0);
      check_eq("rw_stray_req_valid", mem_req_valid, 1'b0);
      check_eq("rw_stray_in_ready", in_ready, 1'b1);
      check_eq("rw_stray_rdata", out_rdata, 64'd0);
      @(negedge clk);
    end

    check_eq("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ysyx_22040125_lsu.md
YSYX_22040125_LSU -- requirements
Module: ysyx_22040125_lsu

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, memory byte-address width; DATA_W, default 64, memory bus width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
REQ-003 SHALL have request-side ports:
- in_valid  in  1  request valid
- in_ready  out  1  LSU accepts request
- in_wen  in  1  1=store, 0=load
- in_size  in  2  0=byte, 1=half, 2=word, 3=double
- in_unsigned  in  1  zero-extend load
- in_addr  in  ADDR_W  byte address, the ALU add result
- in_wdata  in  DATA_W  store data, right-aligned
- in_rd  in  5  destination register tag
REQ-004 SHALL have memory-side ports:
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  8-byte-aligned address
- mem_req_wen  out  1  write enable
- mem_req_wdata  out  DATA_W  lane-shifted store data
- mem_req_wmask  out  8  byte strobes
- mem_rsp_valid  in  1  response valid; the response is always accepted
- mem_rsp_rdata  in  DATA_W  aligned 64-bit read data
REQ-005 SHALL have result-side ports:
- out_valid  out  1  result valid
- out_ready  in  1  writeback accepts result
- out_rdata  out  64  extended load data, 0 for stores
- out_rd  out  5  registered in_rd
- out_misalign  out  1  access was misaligned

Function
REQ-006 SHALL use FSM states IDLE, REQ, WAIT, DONE, with one request in flight at most.
REQ-007 SHALL assert in_ready only in IDLE; a request is captured when in_valid&in_ready, on the same edge as IDLE->REQ.
REQ-008 SHALL treat as misaligned any access where addr[size-1:0]!=0 (size>0); a misaligned request SHALL go IDLE->DONE with out_misalign=1 and out_rdata=0, and mem_req_valid SHALL never assert for it.
REQ-009 SHALL drive mem_req_valid=1 in REQ with mem_req_addr={addr[ADDR_W-1:3],3'b0}.
REQ-010 SHALL drive mem_req_wmask = ((1<<(1<<size))-1)<<addr[2:0] for stores and 8'h00 for loads.
REQ-011 SHALL drive mem_req_wdata = in_wdata<<(8*addr[2:0]).
REQ-012 SHALL hold all mem_req_* stable while mem_req_valid&!mem_req_ready, and SHALL transition REQ->WAIT on the handshake.
REQ-013 SHALL go WAIT->DONE on mem_rsp_valid, for both loads and stores, registering the load lane (rdata>>(8*addr[2:0])) truncated to size.
REQ-014 SHALL sign-extend the truncated lane from bit 8*2^size-1 when in_unsigned=0, and zero-extend when in_unsigned=1; size=3 SHALL pass the lane unchanged.
REQ-015 SHALL assert out_valid only in DONE, with out_rdata, out_rd and out_misalign stable until out_ready; DONE->IDLE on out_valid&out_ready.
REQ-016 SHALL ignore mem_rsp_valid outside WAIT.
REQ-017 SHALL give minimum latency from acceptance to out_valid of 3 cycles when mem_req_ready=1 and the response is same-cycle-next, and 1 cycle for misaligned requests.
REQ-018 SHALL have no combinational path from in_valid to in_ready, or from out_ready to out_valid.

Reset
REQ-019 SHALL, on rst_n=0 asynchronously: state=IDLE; in_ready=0 while reset is asserted, then 1; mem_req_valid=0; out_valid=0; out_rdata=0; out_rd=0; out_misalign=0; all captured request registers=0.
REQ-020 SHALL abandon any in-flight transaction on reset mid-operation, and SHALL drop a later stray mem_rsp_valid per REQ-016.

Structure
REQ-021 SHALL place the size encodings (SZ_B/H/W/D), the FSM state typedef and DATA_W in the shared ysyx_22040125 package.
REQ-022 SHALL place the lane extract plus sign/zero extension in one combinational sub-module, ysyx_22040125_load_ext.

Verification
REQ-023 SHALL cover: load byte, addr=0x80000003, rdata=0x00000000_80000000, in_unsigned=0 -> mem_req_addr=0x80000000, wmask=0x00, out_rdata=0xFFFFFFFF_FFFFFF80.
REQ-024 SHALL cover: store half, addr=0x80000006, wdata=0xBEEF -> wmask=0xC0, wdata=0xBEEF0000_00000000, out_rdata=0 after the response.
REQ-025 SHALL cover: load word, addr=0x80000002 -> out_valid with out_misalign=1 one cycle after acceptance, no mem_req_valid pulse.
REQ-026 SHALL cover: mem_req_ready held low 5 cycles -> mem_req_* stable for all 5 cycles, in_ready=0 throughout.
REQ-027 SHALL cover: out_ready low 3 cycles in DONE -> out_* stable, in_valid ignored, then IDLE.
REQ-028 SHALL cover: rst_n pulsed low in WAIT, then mem_rsp_valid=1 -> all outputs at reset values and no out_valid.
